// File: rtl/otbn_pq_ntt_seq_if.sv
// Handshake and control bundle between the PQ controller and the NTT index sequencer.
// master: controller side (start/abort/ready); slave: the sequencer.
interface otbn_pq_ntt_seq_if #(
  parameter int IdxW = 8
);
  logic            start;
  logic [3:0]      log_n;
  logic            inverse;
  logic            abort;
  logic            step_valid;
  logic            step_ready;
  logic [IdxW-1:0] idx0;
  logic [IdxW-1:0] idx1;
  logic [IdxW-1:0] twiddle_idx;
  logic [3:0]      stage;
  logic            last;
  logic            busy;
  logic            done;
  logic            err;
  logic [15:0]     stall_cnt;

  modport master (
    output start, log_n, inverse, abort, step_ready,
    input  step_valid, idx0, idx1, twiddle_idx, stage, last, busy, done, err, stall_cnt
  );

  modport slave (
    input  start, log_n, inverse, abort, step_ready,
    output step_valid, idx0, idx1, twiddle_idx, stage, last, busy, done, err, stall_cnt
  );
endinterface

// File: rtl/otbn_pq_ntt_seq.sv
// NTT butterfly index/twiddle sequencer. Walks all stages of a forward (CT) or
// inverse (GS) transform and emits one (idx0, idx1, twiddle) descriptor per handshake.
// Optional stall counter enabled by defining OTBN_PQ_NTT_SEQ_STALL_CNT_EN.
module otbn_pq_ntt_seq #(
  parameter int MaxLogN = 8,
  parameter int IdxW    = MaxLogN
) (
  input logic             clk_i,
  input logic             rst_ni,
  otbn_pq_ntt_seq_if.slave bus
);

  // One extra bit so block-start + 2*len can reach N without wrapping.
  localparam int CW = IdxW + 1;

  typedef enum logic [1:0] {Idle, Run, Done} state_e;

  state_e          state_reg, state_next;
  logic [CW-1:0]   n_reg, n_next;
  logic [3:0]      log_n_reg, log_n_next;
  logic            inv_reg, inv_next;
  logic [CW-1:0]   len_reg, len_next;
  logic [CW-1:0]   blk_reg, blk_next;
  logic [CW-1:0]   j_reg, j_next;
  logic [CW-1:0]   k_reg, k_next;
  logic [3:0]      stage_reg, stage_next;
  logic [IdxW-1:0] idx1_reg, idx1_next;
  logic            valid_reg, valid_next;
  logic            last_reg, last_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;

  // Position of the descriptor following the current one.
  logic [CW-1:0]   adv_len, adv_blk, adv_j, adv_k;
  logic [3:0]      adv_stage;
  logic [CW-1:0]   start_n;
  logic            start_legal;

  // True when (j, blk, len, stage) is the final butterfly of the transform.
  function automatic logic is_last(input logic [3:0] stg, input logic [3:0] lgn,
                                   input logic [CW-1:0] j, input logic [CW-1:0] blk,
                                   input logic [CW-1:0] len, input logic [CW-1:0] n);
    return (stg == lgn - 4'd1) && (j + CW'(1) == blk + len) && (blk + (len << 1) == n);
  endfunction

  assign start_n     = CW'(1) << bus.log_n;
  assign start_legal = (bus.log_n >= 4'd1) && (32'(bus.log_n) <= MaxLogN);

  // Next butterfly position: step j, then block, then stage.
  always_comb begin
    adv_len   = len_reg;
    adv_blk   = blk_reg;
    adv_j     = j_reg + CW'(1);
    adv_k     = k_reg;
    adv_stage = stage_reg;
    if (adv_j == blk_reg + len_reg) begin
      adv_k = inv_reg ? k_reg - CW'(1) : k_reg + CW'(1);
      if (blk_reg + (len_reg << 1) == n_reg) begin
        adv_blk   = '0;
        adv_j     = '0;
        adv_stage = stage_reg + 4'd1;
        adv_len   = inv_reg ? (len_reg << 1) : (len_reg >> 1);
      end else begin
        adv_blk = blk_reg + (len_reg << 1);
        adv_j   = blk_reg + (len_reg << 1);
      end
    end
  end

  // Controller next-state and registered-output logic.
  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    log_n_next = log_n_reg;
    inv_next   = inv_reg;
    len_next   = len_reg;
    blk_next   = blk_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    stage_next = stage_reg;
    idx1_next  = idx1_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    unique case (state_reg)
      Idle: begin
        if (bus.start) begin
          if (start_legal) begin
            state_next = Run;
            n_next     = start_n;
            log_n_next = bus.log_n;
            inv_next   = bus.inverse;
            len_next   = bus.inverse ? CW'(1) : (start_n >> 1);
            blk_next   = '0;
            j_next     = '0;
            k_next     = bus.inverse ? start_n - CW'(1) : CW'(1);
            stage_next = '0;
            idx1_next  = bus.inverse ? IdxW'(1) : IdxW'(start_n >> 1);
            valid_next = 1'b1;
            last_next  = (bus.log_n == 4'd1);
            busy_next  = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      Run: begin
        if (bus.abort) begin
          state_next = Idle;
        end else if (valid_reg && bus.step_ready) begin
          if (last_reg) begin
            state_next = Done;
            valid_next = 1'b0;
            last_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            len_next   = adv_len;
            blk_next   = adv_blk;
            j_next     = adv_j;
            k_next     = adv_k;
            stage_next = adv_stage;
            idx1_next  = IdxW'(adv_j + adv_len);
            last_next  = is_last(adv_stage, log_n_reg, adv_j, adv_blk, adv_len, n_reg);
          end
        end
      end
      Done: state_next = Idle;
      default: state_next = Idle;
    endcase
    // Leaving RUN/DONE for IDLE (abort or normal finish) clears all walk state.
    if (state_reg != Idle && state_next == Idle) begin
      n_next     = '0;
      log_n_next = '0;
      inv_next   = 1'b0;
      len_next   = '0;
      blk_next   = '0;
      j_next     = '0;
      k_next     = '0;
      stage_next = '0;
      idx1_next  = '0;
      valid_next = 1'b0;
      last_next  = 1'b0;
      busy_next  = 1'b0;
      done_next  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= Idle;
      n_reg     <= '0;
      log_n_reg <= '0;
      inv_reg   <= 1'b0;
      len_reg   <= '0;
      blk_reg   <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      stage_reg <= '0;
      idx1_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      log_n_reg <= log_n_next;
      inv_reg   <= inv_next;
      len_reg   <= len_next;
      blk_reg   <= blk_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      stage_reg <= stage_next;
      idx1_reg  <= idx1_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign bus.step_valid  = valid_reg;
  assign bus.idx0        = j_reg[IdxW-1:0];
  assign bus.idx1        = idx1_reg;
  assign bus.twiddle_idx = k_reg[IdxW-1:0];
  assign bus.stage       = stage_reg;
  assign bus.last        = last_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.err         = err_reg;

`ifdef OTBN_PQ_NTT_SEQ_STALL_CNT_EN
  logic [15:0] stall_reg;

  // Saturating count of stalled descriptor cycles; cleared by an accepted start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_reg <= '0;
    end else if (state_reg == Idle && bus.start && start_legal) begin
      stall_reg <= '0;
    end else if (valid_reg && !bus.step_ready && stall_reg != 16'hFFFF) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_reg;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_otbn_pq_ntt_seq.sv
// Directed bench for otbn_pq_ntt_seq: small hand-checked transforms, a full
// N=256 forward walk under random back-pressure, illegal sizes, abort and reset.
module tb_otbn_pq_ntt_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_total = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  otbn_pq_ntt_seq_if #(.IdxW(8)) bus ();
  otbn_pq_ntt_seq dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [3:0] lg, input logic inv);
    bus.start = 1'b1;
    bus.log_n = lg;
    bus.inverse = inv;
    tick();
    bus.start = 1'b0;
  endtask

  // Expected descriptors for log_n=2 transforms: {idx0, idx1, k, stage}.
  int fwd2 [4][4] = '{'{0,2,1,0}, '{1,3,1,0}, '{0,1,2,1}, '{2,3,3,1}};
  int inv2 [4][4] = '{'{0,1,3,0}, '{2,3,2,0}, '{0,2,1,1}, '{1,3,1,1}};

  task automatic run_small(input logic inv);
    string nm;
    nm = inv ? "inv2" : "fwd2";
    bus.step_ready = 1'b1;
    start_xfer(4'd2, inv);
    for (int i = 0; i < 4; i++) begin
      int e0, e1, ek, es;
      e0 = inv ? inv2[i][0] : fwd2[i][0];
      e1 = inv ? inv2[i][1] : fwd2[i][1];
      ek = inv ? inv2[i][2] : fwd2[i][2];
      es = inv ? inv2[i][3] : fwd2[i][3];
      $display("%s desc %0d: idx0=%0d idx1=%0d k=%0d stage=%0d last=%0b",
               nm, i, bus.idx0, bus.idx1, bus.twiddle_idx, bus.stage, bus.last);
      check({nm, "_valid"}, 32'(bus.step_valid), 1);
      check({nm, "_idx0"}, 32'(bus.idx0), e0);
      check({nm, "_idx1"}, 32'(bus.idx1), e1);
      check({nm, "_k"}, 32'(bus.twiddle_idx), ek);
      check({nm, "_stage"}, 32'(bus.stage), es);
      check({nm, "_last"}, 32'(bus.last), (i == 3) ? 1 : 0);
      tick();
    end
    check({nm, "_done"}, 32'(bus.done), 1);
    check({nm, "_done_valid"}, 32'(bus.step_valid), 0);
    check({nm, "_done_busy"}, 32'(bus.busy), 1);
    tick();
    check({nm, "_idle_busy"}, 32'(bus.busy), 0);
    check({nm, "_idle_done"}, 32'(bus.done), 0);
  endtask

  initial begin
    int exp0[$], exp1[$], expk[$];
    int kk, hs, seq_err, stab_err, last_err, seen_cnt, first_k, last_k;
    bit seen[256];
    bit got_done, stalled;
    logic [7:0] h0, h1, hk;

    bus.start = 1'b0;
    bus.log_n = '0;
    bus.inverse = 1'b0;
    bus.abort = 1'b0;
    bus.step_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(bus.step_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_idx0", 32'(bus.idx0), 0);
    check("rst_k", 32'(bus.twiddle_idx), 0);
    check("rst_done", 32'(bus.done), 0);
    rst_n = 1'b1;
    tick();

    run_small(1'b0);
    run_small(1'b1);

    // Forward N=256 with random ready.
    kk = 1;
    for (int len = 128; len >= 1; len = len / 2)
      for (int s = 0; s < 256; s += 2 * len) begin
        for (int j = s; j < s + len; j++) begin
          exp0.push_back(j);
          exp1.push_back(j + len);
          expk.push_back(kk);
        end
        kk++;
      end
    hs = 0; seq_err = 0; stab_err = 0; last_err = 0; got_done = 0; stalled = 0;
    first_k = -1; last_k = -1;
    h0 = '0; h1 = '0; hk = '0;
    bus.step_ready = 1'b0;
    start_xfer(4'd8, 1'b0);
    for (int cyc = 0; cyc < 6000 && !got_done; cyc++) begin
      if (bus.done) got_done = 1;
      if (bus.step_valid) begin
        if (stalled && (bus.idx0 != h0 || bus.idx1 != h1 || bus.twiddle_idx != hk)) stab_err++;
        h0 = bus.idx0; h1 = bus.idx1; hk = bus.twiddle_idx;
        bus.step_ready = 1'($urandom_range(0, 1));
        stalled = !bus.step_ready;
        if (bus.step_ready) begin
          if (hs < 1024) begin
            if (32'(bus.idx0) != exp0[hs] || 32'(bus.idx1) != exp1[hs] ||
                32'(bus.twiddle_idx) != expk[hs]) seq_err++;
          end
          if (bus.last != (hs == 1023)) last_err++;
          if (hs == 0) first_k = 32'(bus.twiddle_idx);
          last_k = 32'(bus.twiddle_idx);
          seen[bus.twiddle_idx] = 1'b1;
          hs++;
        end
      end else begin
        stalled = 0;
      end
      if (!got_done) tick();
    end
    seen_cnt = 0;
    for (int i = 1; i < 256; i++) if (seen[i]) seen_cnt++;
    $display("fwd8 handshakes=%0d first_k=%0d last_k=%0d", hs, first_k, last_k);
    check("fwd8_done", 32'(got_done), 1);
    check("fwd8_handshakes", 32'(hs), 1024);
    check("fwd8_seq_errs", 32'(seq_err), 0);
    check("fwd8_stall_hold_errs", 32'(stab_err), 0);
    check("fwd8_last_errs", 32'(last_err), 0);
    check("fwd8_k_seen", 32'(seen_cnt), 255);
    check("fwd8_k0_unused", 32'(seen[0]), 0);
    check("fwd8_first_k", 32'(first_k), 1);
    check("fwd8_last_k", 32'(last_k), 255);
    bus.step_ready = 1'b0;
    tick();
    tick();

    // Illegal sizes.
    start_xfer(4'd0, 1'b0);
    $display("err log_n=0: err=%0b busy=%0b valid=%0b", bus.err, bus.busy, bus.step_valid);
    check("err0_pulse", 32'(bus.err), 1);
    check("err0_busy", 32'(bus.busy), 0);
    check("err0_valid", 32'(bus.step_valid), 0);
    tick();
    check("err0_clear", 32'(bus.err), 0);
    start_xfer(4'd9, 1'b0);
    $display("err log_n=9: err=%0b busy=%0b valid=%0b", bus.err, bus.busy, bus.step_valid);
    check("err9_pulse", 32'(bus.err), 1);
    check("err9_busy", 32'(bus.busy), 0);
    check("err9_valid", 32'(bus.step_valid), 0);
    tick();
    check("err9_clear", 32'(bus.err), 0);

    // Abort after five handshakes of log_n=3.
    bus.step_ready = 1'b1;
    start_xfer(4'd3, 1'b0);
    repeat (5) tick();
    check("abort_pre_idx0", 32'(bus.idx0), 1);
    check("abort_pre_idx1", 32'(bus.idx1), 3);
    check("abort_pre_k", 32'(bus.twiddle_idx), 2);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    $display("abort: valid=%0b busy=%0b done=%0b", bus.step_valid, bus.busy, bus.done);
    check("abort_valid", 32'(bus.step_valid), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    tick();
    check("abort_done_later", 32'(bus.done), 0);
    start_xfer(4'd3, 1'b0);
    check("restart_idx0", 32'(bus.idx0), 0);
    check("restart_idx1", 32'(bus.idx1), 4);
    check("restart_k", 32'(bus.twiddle_idx), 1);
    check("restart_stage", 32'(bus.stage), 0);

    // Asynchronous reset mid-transform.
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", 32'(bus.step_valid), 0);
    check("areset_idx1", 32'(bus.idx1), 0);
    check("areset_busy", 32'(bus.busy), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // log_n=1 with seven stall cycles; start during RUN is ignored.
    bus.step_ready = 1'b0;
    start_xfer(4'd1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      bus.start = (i == 2);
      bus.log_n = 4'd3;
      tick();
    end
    bus.start = 1'b0;
    check("n2_idx0", 32'(bus.idx0), 0);
    check("n2_idx1", 32'(bus.idx1), 1);
    check("n2_k", 32'(bus.twiddle_idx), 1);
    check("n2_last", 32'(bus.last), 1);
    bus.step_ready = 1'b1;
    tick();
    $display("n2: done=%0b stall_cnt=%0d", bus.done, bus.stall_cnt);
    check("n2_done", 32'(bus.done), 1);
`ifdef OTBN_PQ_NTT_SEQ_STALL_CNT_EN
    check("n2_stall_cnt", 32'(bus.stall_cnt), 7);
`else
    check("n2_stall_cnt", 32'(bus.stall_cnt), 0);
`endif
    tick();
    check("n2_idle_busy", 32'(bus.busy), 0);
    check("n2_idle_valid", 32'(bus.step_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
